// File: rtl/adc0809_pkg.sv
// ADC0809 scan controller shared types and constants.
// State encoding, widths, default timing and channel search.
package adc0809_pkg;

  localparam int CH_W   = 3;
  localparam int DATA_W = 8;
  localparam int N_CH   = 1 << CH_W;

  localparam int HALF_DIV_D    = 28;
  localparam int PULSE_CYC_D   = 8;
  localparam int OE_SETTLE_D   = 6;
  localparam int EOC_TIMEOUT_D = 8191;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    WAIT_LO,
    WAIT_HI,
    READ,
    DONE
  } state_t;

  // First enabled channel strictly after cur, wrapping 7 -> 0.
  // A lone enabled channel finds itself after a full lap.
  function automatic logic [CH_W-1:0] next_ch(
    input logic [N_CH-1:0] mask,
    input logic [CH_W-1:0] cur
  );
    logic [CH_W-1:0] idx;
    logic            found;
    next_ch = cur;
    found   = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = cur + CH_W'(i);
      if (!found && mask[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/adc0809_clk_gen.sv
// ADC0809 converter clock prescaler.
// adc_clk toggles every HALF_DIV+1 system clocks.
module adc0809_clk_gen
  import adc0809_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_D
) (
  input  logic clk,
  input  logic rst,
  output logic adc_clk
);

  localparam int CW = $clog2(HALF_DIV + 2);

  logic [CW-1:0] cnt;

  // Free-running half-period counter; toggle on terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      adc_clk <= 1'b0;
    end else if (cnt == CW'(HALF_DIV)) begin
      cnt     <= '0;
      adc_clk <= ~adc_clk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/adc0809_scan_ctrl.sv
// ADC0809 round-robin scan sequencer.
// Drives address/ALE/START/OE and delivers tagged results.
module adc0809_scan_ctrl
  import adc0809_pkg::*;
#(
  parameter int HALF_DIV    = HALF_DIV_D,
  parameter int PULSE_CYC   = PULSE_CYC_D,
  parameter int OE_SETTLE   = OE_SETTLE_D,
  parameter int EOC_TIMEOUT = EOC_TIMEOUT_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_CH-1:0]   ch_mask,
  output logic              adc_clk,
  output logic [CH_W-1:0]   adc_addr,
  output logic              adc_ale,
  output logic              adc_start,
  input  logic              adc_eoc,
  output logic              adc_oe,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] data_out,
  output logic [CH_W-1:0]   ch_out,
  output logic              data_valid,
  output logic              timeout_err,
  output logic              busy
);

  localparam int CNT_MAX =
    (PULSE_CYC > OE_SETTLE) ? PULSE_CYC : OE_SETTLE;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int TMO_W = $clog2(EOC_TIMEOUT + 1);

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [TMO_W-1:0]  tmo;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   sel_ch;
  logic              eoc_m;
  logic              eoc_s;
  logic              go;
  logic              ld_ch;
  logic              cap;
  logic              tmo_hit;
  logic              pulse_end;
  logic              read_end;
  logic              tmo_last;
  logic              timed;

  adc0809_clk_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .adc_clk (adc_clk)
  );

  assign sel_ch    = next_ch(ch_mask, cur_ch);
  assign go        = en && (ch_mask != '0);
  assign pulse_end = cnt == CNT_W'(PULSE_CYC - 1);
  assign read_end  = cnt == CNT_W'(OE_SETTLE - 1);
  assign tmo_last  = tmo == TMO_W'(EOC_TIMEOUT - 1);
  assign timed     = (state == WAIT_LO) || (state == WAIT_HI);

  // Two-flop synchroniser for the asynchronous EOC pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eoc_m <= 1'b0;
      eoc_s <= 1'b0;
    end else begin
      eoc_m <= adc_eoc;
      eoc_s <= eoc_m;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state decode; a timeout exits exactly like DONE.
  always_comb begin
    state_n = state;
    ld_ch   = 1'b0;
    cap     = 1'b0;
    tmo_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_n = SETUP;
          ld_ch   = 1'b1;
        end
      end
      SETUP: begin
        if (pulse_end) state_n = PULSE;
      end
      PULSE: begin
        if (pulse_end) state_n = WAIT_LO;
      end
      WAIT_LO: begin
        if (!eoc_s)        state_n = WAIT_HI;
        else if (tmo_last) tmo_hit = 1'b1;
      end
      WAIT_HI: begin
        if (eoc_s)         state_n = READ;
        else if (tmo_last) tmo_hit = 1'b1;
      end
      READ: begin
        if (read_end) begin
          state_n = DONE;
          cap     = 1'b1;
        end
      end
      DONE: begin
        state_n = go ? SETUP : IDLE;
        ld_ch   = go;
      end
      default: state_n = IDLE;
    endcase
    if (tmo_hit) begin
      state_n = go ? SETUP : IDLE;
      ld_ch   = go;
    end
  end

  // Phase counter restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else if (state == SETUP || state == PULSE ||
                 state == READ) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // EOC watchdog spans both wait states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo <= '0;
    end else if (state_n == WAIT_LO && state != WAIT_LO) begin
      tmo <= '0;
    end else if (timed) begin
      tmo <= tmo + TMO_W'(1);
    end
  end

  // Registered pin and result outputs, decoded from next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_ch      <= '1;
      adc_addr    <= '0;
      adc_ale     <= 1'b0;
      adc_start   <= 1'b0;
      adc_oe      <= 1'b0;
      data_out    <= '0;
      ch_out      <= '0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      adc_ale     <= state_n == PULSE;
      adc_start   <= state_n == PULSE;
      adc_oe      <= state_n == READ;
      data_valid  <= cap;
      timeout_err <= tmo_hit;
      busy        <= state_n != IDLE;
      if (ld_ch) begin
        cur_ch   <= sel_ch;
        adc_addr <= sel_ch;
      end
      if (cap) begin
        data_out <= adc_data;
        ch_out   <= adc_addr;
      end
    end
  end

endmodule

// File: tb/tb_adc0809_scan_ctrl.sv
// Self-checking bench for adc0809_scan_ctrl.
// Behavioural ADC0809 model plus channel-order scoreboard.
`timescale 1ns/1ps
module tb_adc0809_scan_ctrl;

  localparam int PULSE = 8;
  localparam int OESET = 6;
  localparam int TMO   = 8191;
  localparam int LAT   = 2 + OESET + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic       adc_clk;
  logic [2:0] adc_addr;
  logic       adc_ale;
  logic       adc_start;
  logic       adc_eoc = 1'b1;
  logic       adc_oe;
  logic [7:0] adc_data;
  logic [7:0] data_out;
  logic [2:0] ch_out;
  logic       data_valid;
  logic       timeout_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  adc0809_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ch_mask     (ch_mask),
    .adc_clk     (adc_clk),
    .adc_addr    (adc_addr),
    .adc_ale     (adc_ale),
    .adc_start   (adc_start),
    .adc_eoc     (adc_eoc),
    .adc_oe      (adc_oe),
    .adc_data    (adc_data),
    .data_out    (data_out),
    .ch_out      (ch_out),
    .data_valid  (data_valid),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] ch;
    logic [7:0] d;
    int         t;
  } conv_t;

  conv_t      q[$];
  conv_t      cv;
  logic [2:0] got_ch[$];
  int         cyc = 0;
  bit         stuck = 1'b0;
  bit         fix_en = 1'b0;
  logic [7:0] fix_d = 8'h00;
  bit         rnd_dly = 1'b0;
  int         lo_dly = 30;
  int         hi_dly = 120;
  bit         a_act = 1'b0;
  int         a_t = 0;
  int         a_lo = 0;
  int         a_hi = 0;
  logic [2:0] a_ch = 3'd0;
  logic [7:0] a_res = 8'h00;
  int         exp_prev = 7;
  int         e;
  int         nvalid = 0;
  int         nstart = 0;
  logic       start_q = 1'b0;
  logic [2:0] addr_q = 3'd0;
  int         age = 0;
  bit         moved = 1'b0;
  int         ale_w = 0;
  int         st_w = 0;
  int         oe_w = 0;
  int         dv_w = 0;
  int         te_w = 0;

  assign adc_data = adc_oe ? a_res : 8'h00;

  function automatic int ref_next(input logic [7:0] m,
                                  input int prev);
    for (int k = 1; k <= 8; k++)
      if (m[(prev + k) % 8]) return (prev + k) % 8;
    return prev;
  endfunction

  // Converter model and protocol monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      q.delete();
      exp_prev = 7;
      a_act    = 1'b0;
      adc_eoc  = 1'b1;
      start_q  = 1'b0;
      addr_q   = 3'd0;
      age      = 0;
      moved    = 1'b0;
      ale_w    = 0;
      st_w     = 0;
      oe_w     = 0;
      dv_w     = 0;
      te_w     = 0;
    end else begin
      if (adc_addr == addr_q) age++;
      else                    age = 0;
      if ((adc_ale || adc_oe) && adc_addr != addr_q)
        moved = 1'b1;
      addr_q = adc_addr;
      if (adc_start && !start_q) begin
        e = ref_next(ch_mask, exp_prev);
        chk("start_addr", int'(adc_addr), e);
        chk("addr_setup", int'(age >= PULSE), 1);
        exp_prev = e;
        nstart++;
        a_act = !stuck;
        a_t   = 0;
        a_ch  = adc_addr;
        a_lo  = rnd_dly ? $urandom_range(60, 1) : lo_dly;
        a_hi  = rnd_dly ? $urandom_range(300, 20) : hi_dly;
      end
      start_q = adc_start;
      if (stuck) begin
        adc_eoc = 1'b1;
      end else if (a_act) begin
        a_t++;
        if (a_t == a_lo) adc_eoc = 1'b0;
        if (a_t == a_lo + a_hi) begin
          adc_eoc = 1'b1;
          a_act   = 1'b0;
          a_res   = fix_en ? fix_d : 8'($urandom);
          cv.ch   = a_ch;
          cv.d    = a_res;
          cv.t    = cyc;
          q.push_back(cv);
        end
      end
      if (data_valid) begin
        nvalid++;
        got_ch.push_back(ch_out);
        chk("valid_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          cv = q.pop_front();
          chk("ch_out", int'(ch_out), int'(cv.ch));
          chk("data_out", int'(data_out), int'(cv.d));
          chk("latency", cyc - cv.t, LAT);
        end
      end
      if (adc_ale) ale_w++;
      else if (ale_w != 0) begin
        chk("ale_width", ale_w, PULSE);
        chk("addr_hold_ale", int'(moved), 0);
        moved = 1'b0;
        ale_w = 0;
      end
      if (adc_start) st_w++;
      else if (st_w != 0) begin
        chk("start_width", st_w, PULSE);
        st_w = 0;
      end
      if (adc_oe) oe_w++;
      else if (oe_w != 0) begin
        chk("oe_width", oe_w, OESET);
        chk("addr_hold_oe", int'(moved), 0);
        moved = 1'b0;
        oe_w  = 0;
      end
      if (data_valid) dv_w++;
      else if (dv_w != 0) begin
        chk("valid_width", dv_w, 1);
        dv_w = 0;
      end
      if (timeout_err) te_w++;
      else if (te_w != 0) begin
        chk("tmo_width", te_w, 1);
        te_w = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    tick(3);
    chk("rst_outs", int'({adc_clk, adc_addr, adc_ale,
        adc_start, adc_oe, data_out, ch_out, data_valid,
        timeout_err, busy}), 0);
    rst = 1'b1;
  endtask

  task automatic wait_valids(input int target, input int budget,
                             input string name);
    int n;
    n = 0;
    while (nvalid < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(nvalid >= target), 1);
  endtask

  typedef struct {
    logic [7:0] mask;
    int         n;
    int         exp_ch[5];
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n;
    int h;
    int l;
    int s0;
    int got;

    tbl[0].mask = 8'h04;        tbl[0].n = 3;
    tbl[0].exp_ch = '{2, 2, 2, 0, 0};
    tbl[1].mask = 8'b1001_0010; tbl[1].n = 5;
    tbl[1].exp_ch = '{1, 4, 7, 1, 4};
    tbl[2].mask = 8'h80;        tbl[2].n = 2;
    tbl[2].exp_ch = '{7, 7, 0, 0, 0};
    tbl[3].mask = 8'h01;        tbl[3].n = 2;
    tbl[3].exp_ch = '{0, 0, 0, 0, 0};
    tbl[4].mask = 8'hFF;        tbl[4].n = 4;
    tbl[4].exp_ch = '{0, 1, 2, 3, 0};
    tbl[5].mask = 8'h81;        tbl[5].n = 3;
    tbl[5].exp_ch = '{0, 7, 0, 0, 0};

    // Converter clock period and duty after reset.
    do_reset();
    n = 0;
    while (adc_clk && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (!adc_clk && n < 200) begin @(negedge clk); n++; end
    h = 0;
    while (adc_clk && h < 200) begin @(negedge clk); h++; end
    l = 0;
    while (!adc_clk && l < 200) begin @(negedge clk); l++; end
    chk("adc_clk_high", h, 29);
    chk("adc_clk_period", h + l, 58);

    // Table-driven scan order per mask.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ch_mask = tbl[i].mask;
      got_ch.delete();
      nvalid = 0;
      en = 1'b1;
      wait_valids(tbl[i].n, 3000 * tbl[i].n, "tbl_valids");
      en = 1'b0;
      for (int k = 0; k < tbl[i].n; k++) begin
        got = (k < got_ch.size()) ? int'(got_ch[k]) : -1;
        chk($sformatf("tbl%0d_ch%0d", i, k), got,
            tbl[i].exp_ch[k]);
      end
    end

    // Single channel with realistic EOC timing and fixed data.
    do_reset();
    ch_mask = 8'h04;
    fix_en  = 1'b1;
    fix_d   = 8'hA5;
    lo_dly  = 250;
    hi_dly  = 2500;
    nvalid  = 0;
    en      = 1'b1;
    wait_valids(2, 8000, "single_valids");
    en = 1'b0;
    chk("single_data", int'(data_out), 8'hA5);
    chk("single_ch", int'(ch_out), 2);
    fix_en = 1'b0;
    lo_dly = 30;
    hi_dly = 120;

    // EOC stuck high: timeout, then next channel.
    do_reset();
    ch_mask = 8'h06;
    stuck   = 1'b1;
    nvalid  = 0;
    s0      = nstart;
    en      = 1'b1;
    n = 0;
    while (nstart == s0 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (adc_start && n < 100) begin @(negedge clk); n++; end
    h = 0;
    while (!timeout_err && h < 9000) begin
      h++;
      @(negedge clk);
    end
    chk("tmo_wait", h, TMO);
    chk("tmo_data_kept", int'(data_out), 0);
    s0 = nstart;
    n = 0;
    while (nstart == s0 && n < 100) begin @(negedge clk); n++; end
    chk("tmo_next_start", int'(nstart > s0), 1);
    chk("tmo_next_ch", int'(adc_addr), 2);
    chk("tmo_no_valid", nvalid, 0);
    stuck = 1'b0;

    // Drop en during WAIT_HI: finish, then stop.
    do_reset();
    ch_mask = 8'h08;
    nvalid  = 0;
    en      = 1'b1;
    n = 0;
    while (adc_eoc && n < 500) begin @(negedge clk); n++; end
    tick(PULSE + 6);
    en = 1'b0;
    wait_valids(1, 1000, "stop_valid");
    tick(2);
    chk("stop_busy", int'(busy), 0);
    s0 = nstart;
    tick(500);
    chk("stop_no_start", nstart, s0);
    chk("stop_one_valid", nvalid, 1);

    // Enabled with empty mask stays idle.
    do_reset();
    ch_mask = 8'h00;
    s0 = nstart;
    en = 1'b1;
    tick(50);
    chk("empty_busy", int'(busy), 0);
    chk("empty_no_start", nstart, s0);
    en = 1'b0;

    // Asynchronous reset during READ.
    do_reset();
    ch_mask = 8'b0011_0000;
    en = 1'b1;
    n = 0;
    while (!adc_oe && n < 1000) begin @(negedge clk); n++; end
    chk("abort_in_read", int'(adc_oe), 1);
    #5;
    rst = 1'b0;
    #1;
    chk("abort_oe", int'(adc_oe), 0);
    chk("abort_outs", int'({adc_clk, adc_addr, adc_ale,
        adc_start, adc_oe, data_out, ch_out, data_valid,
        timeout_err, busy}), 0);
    tick(2);
    got_ch.delete();
    nvalid = 0;
    rst = 1'b1;
    wait_valids(1, 1000, "abort_restart");
    got = (got_ch.size() > 0) ? int'(got_ch[0]) : -1;
    chk("abort_first_ch", got, 4);
    en = 1'b0;

    // Randomised masks and EOC timing against the model.
    do_reset();
    rnd_dly = 1'b1;
    for (int s = 0; s < 4; s++) begin
      ch_mask = 8'($urandom_range(255, 1));
      nvalid  = 0;
      en      = 1'b1;
      wait_valids(4, 2800, "rnd_valids");
      en = 1'b0;
      n = 0;
      while (busy && n < 1000) begin @(negedge clk); n++; end
      chk("rnd_idle", int'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
